rom_fetch: RTL

//   Bus-side initiator for a synchronous 1-cycle-latency ROM (rom_addr -> rom_q registered on clk).

---
 rtl/rom_fetch.sv | 99 +++++++++
 1 files changed

// File: rtl/rom_fetch.sv
// rom_fetch: fetches a 32-bit word as two halfword reads from a 1-cycle-latency ROM and flags illegal addresses.
// Define ROM_FETCH_CACHE_EN to add a one-entry cache of the most recent legal fetch.
module rom_fetch #(
  parameter int ROM_ADDR_WIDTH = 14,
  parameter int ROM_DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_data,
  output logic                      rsp_err,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [ROM_DATA_WIDTH-1:0] rom_q
);
  localparam int AW = ROM_ADDR_WIDTH;
  typedef enum logic [2:0] {IDLE, LO, HI, CAP, RESP} state_t;
  state_t state, next;
  logic [AW-1:0] idx;
  logic [ROM_DATA_WIDTH-1:0] lo;
  logic bad, accept, hit;
  logic [31:0] hit_data;
  assign idx = req_addr[AW:1];
  // the top halfword index is illegal because its upper half would wrap to 0
  assign bad = req_addr[0] | (|req_addr[31:AW+1]) | (&idx);
  assign req_ready = state == IDLE;
  assign accept = req_valid && req_ready;
`ifdef ROM_FETCH_CACHE_EN
  logic c_valid;
  logic [31:0] c_tag, c_data, addr_r;
  assign hit = c_valid && c_tag == req_addr;
  assign hit_data = c_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_tag <= '0;
      c_data <= '0;
      addr_r <= '0;
    end else begin
      if (accept) addr_r <= req_addr;
      if (state == CAP) begin
        c_valid <= 1'b1;
        c_tag <= addr_r;
        c_data <= {rom_q, lo};
      end
    end
`else
  assign hit = 1'b0;
  assign hit_data = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = accept ? ((bad || hit) ? RESP : LO) : IDLE;
      LO: next = HI;
      HI: next = CAP;
      CAP: next = RESP;
      RESP: next = (rsp_valid && rsp_ready) ? IDLE : RESP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rom_addr <= '0;
      lo <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (accept) begin
            if (bad) begin
              rsp_err <= 1'b1;
              rsp_data <= '0;
            end else if (hit) begin
              rsp_err <= 1'b0;
              rsp_data <= hit_data;
            end else rom_addr <= idx;
          end
        LO: rom_addr <= rom_addr + 1'b1;
        HI: lo <= rom_q;
        CAP: begin
          rsp_data <= {rom_q, lo};
          rsp_err <= 1'b0;
          rsp_valid <= 1'b1;
        end
        // error and cache-hit responses arrive here with rsp_valid still low and raise it one cycle later
        RESP: rsp_valid <= !(rsp_valid && rsp_ready);
        default: ;
      endcase
    end
endmodule
